timer_counter: RTL

Memory-mapped countdown timer that sits behind the system bridge as its timer device: it responds to the processor's bus at word window 0x0000_7F00–0x0000_7F0F. It receives the bridge's decoded timer write enable, returns read data for the addressed register, and drives the interrupt request that the bridge forwards as HWInt[0]. It supports a one-shot mode and an auto-reload mode with a maskable interrupt.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/timer_counter.sv | 93 +++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states, register
// word offsets, CTRL bit positions and mode encodings.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } timer_state_e;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPreset = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;

  localparam int unsigned CtrlEn      = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlIm      = 3;

  localparam logic [1:0] ModeOneshot = 2'b00;
  localparam logic [1:0] ModeReload  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer behind the system bridge: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload operation and a maskable interrupt request.
module timer_counter
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  timer_state_e state_q;
  logic [3:0]   ctrl_q;
  logic [31:0]  preset_q;
  logic [31:0]  count_q;
  logic         pending_q;

  logic en;
  logic reload;
  logic reg_wr;
  logic pend_set;
  logic pend_clr;

  assign en       = ctrl_q[CtrlEn];
  // Modes 10 and 11 fall through to one-shot behaviour.
  assign reload   = (ctrl_q[CtrlModeMsb:CtrlModeLsb] == ModeReload);
  assign reg_wr   = we && ((addr == RegCtrl) || (addr == RegPreset));
  assign pend_set = (state_q == StCnt) && en && (count_q <= 32'd1);
  assign pend_clr = (state_q == StInt) && reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ctrl_q    <= 4'd0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (en) state_q <= StLoad;
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q <= 32'd0;
            state_q <= StInt;
          end
        end
        StInt: begin
          if (reload) begin
            state_q <= StLoad;
          end else begin
            ctrl_q[CtrlEn] <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // CPU writes come after the FSM so a same-cycle CTRL write overrides the EN clear.
      if (we && (addr == RegCtrl))   ctrl_q   <= wd[3:0];
      if (we && (addr == RegPreset)) preset_q <= wd;

      // A same-cycle set beats any clear so no expiry is lost.
      if (pend_set)                pending_q <= 1'b1;
      else if (reg_wr || pend_clr) pending_q <= 1'b0;
    end
  end

  always_comb begin
    rd = 32'd0;
    case (addr)
      RegCtrl:   rd = {27'd0, pending_q, ctrl_q};
      RegPreset: rd = preset_q;
      RegCount:  rd = count_q;
      default:   rd = 32'd0;
    endcase
  end

  assign irq = pending_q & ctrl_q[CtrlIm];

endmodule
